// File: rtl/ntt_seq_pkg.sv
// Shared types and constants for the NTT stage sequencer.
// Optional watchdog build switch: NTT_SEQ_WATCHDOG_EN.
package ntt_seq_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } seq_state_t;

  // Burst counter width used by the default transform (2048 points, 256-beat bursts)
  localparam int unsigned CNT_W_DEFAULT = 32'd8;

  // Terminal count of the default burst counter
  localparam int unsigned CNT_TERMINAL = (32'd1 << CNT_W_DEFAULT) - 32'd1;

  // Extra RUN cycles tolerated past a full burst before the watchdog trips
  localparam int unsigned WD_SLACK = 32'd8;

  // RUN-cycle limit of the default build
  localparam int unsigned WD_LIMIT = (32'd1 << CNT_W_DEFAULT) + WD_SLACK;

  // Terminal count for an arbitrary counter width
  function automatic int unsigned terminal_of(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Watchdog RUN-cycle limit for an arbitrary counter width
  function automatic int unsigned wd_limit_of(input int unsigned w);
    return (32'd1 << w) + WD_SLACK;
  endfunction

endpackage

// File: rtl/ntt_stage_sequencer_if.sv
// Handshake bundle between transform controller, sequencer and burst counter.
// master = controller/counter side, slave = sequencer.
// err exists only when NTT_SEQ_WATCHDOG_EN is defined.
interface ntt_stage_sequencer_if #(
  parameter int CNT_W   = 8,
  parameter int STAGE_W = 4
) ();

  logic               go;
  logic               abort;
  logic [CNT_W-1:0]   cnt_in;
  logic               cnt_start;
  logic [STAGE_W-1:0] stage_idx;
  logic               stage_active;
  logic               busy;
  logic               done;
`ifdef NTT_SEQ_WATCHDOG_EN
  logic               err;
`endif

  modport master (
    output go,
    output abort,
    output cnt_in,
    input  cnt_start,
    input  stage_idx,
    input  stage_active,
    input  busy,
    input  done
`ifdef NTT_SEQ_WATCHDOG_EN
    , input err
`endif
  );

  modport slave (
    input  go,
    input  abort,
    input  cnt_in,
    output cnt_start,
    output stage_idx,
    output stage_active,
    output busy,
    output done
`ifdef NTT_SEQ_WATCHDOG_EN
    , output err
`endif
  );

endinterface

// File: rtl/ntt_drain_timer.sv
// Loadable down-counter timing the pipeline-drain gap between stages.
// expire is high during the last of the PIPE_GAP drain cycles.
module ntt_drain_timer #(
  parameter int PIPE_GAP = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);

  localparam int GAP_W = (PIPE_GAP < 1) ? 1 : $clog2(PIPE_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_ZERO = GAP_W'(0);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(PIPE_GAP);

  logic [GAP_W-1:0] count_r;

  // Load the gap length on DRAIN entry, then count down and park at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= GAP_ZERO;
    end else if (load) begin
      count_r <= GAP_LOAD;
    end else if (count_r != GAP_ZERO) begin
      count_r <= count_r - GAP_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expire = (count_r == GAP_ONE);

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Sequences the burst counter through every butterfly stage of one NTT:
// launch pulse, wait for terminal count, drain gap, next stage, done pulse.
// Optional RUN watchdog with sticky err output: define NTT_SEQ_WATCHDOG_EN.
module ntt_stage_sequencer
  import ntt_seq_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int STAGES   = 11,
  parameter int STAGE_W  = 4,
  parameter int PIPE_GAP = 4
) (
  input logic                 clk,
  input logic                 rst,
  ntt_stage_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0]   TERM       = CNT_W'(terminal_of(CNT_W));
  localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGES - 1);
  localparam logic [STAGE_W-1:0] STAGE_ONE  = STAGE_W'(1);
  localparam logic [STAGE_W-1:0] STAGE_ZERO = STAGE_W'(0);

  seq_state_t         state_r;
  seq_state_t         state_s;
  logic [STAGE_W-1:0] stage_idx_r;
  logic [STAGE_W-1:0] stage_idx_s;
  logic               drain_load_s;
  logic               drain_expire_s;
  logic               last_stage_s;
  logic               cnt_start_r;
  logic               stage_active_r;
  logic               busy_r;
  logic               done_r;

`ifdef NTT_SEQ_WATCHDOG_EN
  // Wide enough to count past 2^CNT_W + slack
  localparam int              WD_W    = CNT_W + 2;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(wd_limit_of(CNT_W) - 32'd1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0] WD_ZERO = WD_W'(0);

  logic [WD_W-1:0] run_cnt_r;
  logic            wd_trip_s;
  logic            err_r;
`endif

  ntt_drain_timer #(
    .PIPE_GAP (PIPE_GAP)
  ) u_drain_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (drain_load_s),
    .expire (drain_expire_s)
  );

  assign last_stage_s = (stage_idx_r == LAST_STAGE);

  // Next-state and stage-index selection; abort overrides every state
  always_comb begin
    state_s      = state_r;
    stage_idx_s  = stage_idx_r;
    drain_load_s = 1'b0;
`ifdef NTT_SEQ_WATCHDOG_EN
    wd_trip_s    = 1'b0;
`endif
    if (bus.abort) begin
      state_s     = IDLE;
      stage_idx_s = STAGE_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.go) begin
            state_s     = LAUNCH;
            stage_idx_s = STAGE_ZERO;
          end else begin
            state_s = IDLE;
          end
        end
        LAUNCH: begin
          // cnt_in still holds the previous burst here, so it is not looked at
          state_s = RUN;
        end
        RUN: begin
          if (bus.cnt_in == TERM) begin
            if (PIPE_GAP > 0) begin
              state_s      = DRAIN;
              drain_load_s = 1'b1;
            end else if (last_stage_s) begin
              state_s = FINISH;
            end else begin
              state_s     = LAUNCH;
              stage_idx_s = stage_idx_r + STAGE_ONE;
            end
`ifdef NTT_SEQ_WATCHDOG_EN
          end else if (run_cnt_r == WD_LAST) begin
            state_s     = IDLE;
            stage_idx_s = STAGE_ZERO;
            wd_trip_s   = 1'b1;
`endif
          end else begin
            state_s = RUN;
          end
        end
        DRAIN: begin
          if (!drain_expire_s) begin
            state_s = DRAIN;
          end else if (last_stage_s) begin
            state_s = FINISH;
          end else begin
            state_s     = LAUNCH;
            stage_idx_s = stage_idx_r + STAGE_ONE;
          end
        end
        FINISH: begin
          state_s     = IDLE;
          stage_idx_s = STAGE_ZERO;
        end
        default: begin
          state_s     = IDLE;
          stage_idx_s = STAGE_ZERO;
        end
      endcase
    end
  end

  // State register plus outputs registered from the next state (Moore timing)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      stage_idx_r    <= STAGE_ZERO;
      cnt_start_r    <= 1'b0;
      stage_active_r <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
    end else begin
      state_r        <= state_s;
      stage_idx_r    <= stage_idx_s;
      cnt_start_r    <= (state_s == LAUNCH);
      stage_active_r <= (state_s == RUN);
      busy_r         <= (state_s != IDLE);
      done_r         <= (state_s == FINISH);
    end
  end

`ifdef NTT_SEQ_WATCHDOG_EN
  // Count consecutive RUN cycles; zero in the first RUN cycle of each stage
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_r <= WD_ZERO;
    end else if (state_r == RUN) begin
      run_cnt_r <= run_cnt_r + WD_ONE;
    end else begin
      run_cnt_r <= WD_ZERO;
    end
  end

  // Sticky error flag, only rst clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (wd_trip_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign bus.err = err_r;
`endif

  assign bus.cnt_start    = cnt_start_r;
  assign bus.stage_idx    = stage_idx_r;
  assign bus.stage_active = stage_active_r;
  assign bus.busy         = busy_r;
  assign bus.done         = done_r;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Scoreboard bench for ntt_stage_sequencer: two instances (default build and
// PIPE_GAP=0/STAGES=2), each driving a behavioural 256-beat burst counter.
// Watchdog checks run only when NTT_SEQ_WATCHDOG_EN is defined.
module tb_ntt_stage_sequencer;

  localparam int PER_A = 261;  // 257 + PIPE_GAP(4)
  localparam int PER_B = 257;  // 257 + PIPE_GAP(0)

  typedef struct {
    int kind;   // 0 = cnt_start, 1 = done
    int cyc;
    int stage;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  logic stuck = 1'b0;
  ev_t  qa[$];
  ev_t  qb[$];

  logic [7:0] cnt_a_r;
  logic [7:0] cnt_b_r;

  ntt_stage_sequencer_if #(.CNT_W(8), .STAGE_W(4)) bus_a ();
  ntt_stage_sequencer_if #(.CNT_W(8), .STAGE_W(4)) bus_b ();

  ntt_stage_sequencer #(.CNT_W(8), .STAGES(11), .STAGE_W(4), .PIPE_GAP(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  ntt_stage_sequencer #(.CNT_W(8), .STAGES(2), .STAGE_W(4), .PIPE_GAP(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  // Cycle number: cycle n is the interval following the n-th rising edge
  always @(posedge clk) cyc <= cyc + 1;

  // Burst counters: zero in the cycle after a start pulse, then count up
  always @(posedge clk) begin
    if (rst || bus_a.cnt_start) cnt_a_r <= 8'd0;
    else                        cnt_a_r <= cnt_a_r + 8'd1;
    if (rst || bus_b.cnt_start) cnt_b_r <= 8'd0;
    else                        cnt_b_r <= cnt_b_r + 8'd1;
  end

  assign bus_a.cnt_in = stuck ? 8'd17 : cnt_a_r;
  assign bus_b.cnt_in = cnt_b_r;

  task automatic chk(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, got, exp);
    end
  endtask

  task automatic cmp_ev(input string nm, input ev_t e, input int kind, input int stage);
    n_vec++;
    if (e.kind != kind || e.cyc != cyc || e.stage != stage) begin
      n_fail++;
      $display("FAIL %s: got kind=%0d cycle=%0d stage=%0d, expected kind=%0d cycle=%0d stage=%0d",
               nm, kind, cyc, stage, e.kind, e.cyc, e.stage);
    end
  endtask

  task automatic unexpected(input string nm, input int stage);
    n_vec++;
    n_fail++;
    $display("FAIL %s: got unexpected event at cycle %0d stage=%0d, expected none", nm, cyc, stage);
  endtask

  // Expected events of one transform launched by go in cycle t0
  task automatic push_xform(input bit to_b, input int t0, input int stages, input int per,
                            input int n_starts, input bit with_done);
    ev_t e;
    for (int k = 0; k < n_starts; k++) begin
      e.kind = 0; e.cyc = t0 + 1 + k * per; e.stage = k;
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
    if (with_done) begin
      e.kind = 1; e.cyc = t0 + 1 + stages * per; e.stage = stages - 1;
      if (to_b) qb.push_back(e); else qa.push_back(e);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every cnt_start/done pulse is matched against the scoreboard
  always @(negedge clk) begin
    if (bus_a.cnt_start) begin
      if (qa.size() == 0) unexpected("a_start", int'(bus_a.stage_idx));
      else cmp_ev("a_start", qa.pop_front(), 0, int'(bus_a.stage_idx));
    end
    if (bus_a.done) begin
      if (qa.size() == 0) unexpected("a_done", int'(bus_a.stage_idx));
      else cmp_ev("a_done", qa.pop_front(), 1, int'(bus_a.stage_idx));
    end
    if (bus_b.cnt_start) begin
      if (qb.size() == 0) unexpected("b_start", int'(bus_b.stage_idx));
      else cmp_ev("b_start", qb.pop_front(), 0, int'(bus_b.stage_idx));
    end
    if (bus_b.done) begin
      if (qb.size() == 0) unexpected("b_done", int'(bus_b.stage_idx));
      else cmp_ev("b_done", qb.pop_front(), 1, int'(bus_b.stage_idx));
    end
  end

  // Global time bound
  always @(posedge clk) begin
    if (cyc > 40000) begin
      $display("FAIL timeout: got cycle %0d, expected end before 40000", cyc);
      $fatal(1, "bench timeout");
    end
  end

  initial begin
    int t0;
    bus_a.go = 1'b0; bus_a.abort = 1'b0;
    bus_b.go = 1'b0; bus_b.abort = 1'b0;

    // Reset values
    goto(3);
    chk("rst_cnt_start", int'(bus_a.cnt_start), 0);
    chk("rst_stage_active", int'(bus_a.stage_active), 0);
    chk("rst_busy", int'(bus_a.busy), 0);
    chk("rst_done", int'(bus_a.done), 0);
    chk("rst_stage_idx", int'(bus_a.stage_idx), 0);
`ifdef NTT_SEQ_WATCHDOG_EN
    chk("rst_err", int'(bus_a.err), 0);
`endif
    rst = 1'b0;

    // PIPE_GAP=0, STAGES=2: starts at +1, +258, done at +515
    t0 = 6;
    goto(t0);
    bus_b.go = 1'b1;
    push_xform(1'b1, t0, 2, PER_B, 2, 1'b1);
    goto(t0 + 1);
    bus_b.go = 1'b0;
    goto(t0 + 259);
    chk("b_stage1_active", int'(bus_b.stage_active), 1);
    goto(t0 + 515);
    chk("b_busy_at_done", int'(bus_b.busy), 1);
    goto(t0 + 516);
    chk("b_busy_after", int'(bus_b.busy), 0);

    // Full default transform: done at +2872
    t0 = 530;
    goto(t0);
    chk("a_busy_idle", int'(bus_a.busy), 0);
    bus_a.go = 1'b1;
    push_xform(1'b0, t0, 11, PER_A, 11, 1'b1);
    goto(t0 + 1);
    bus_a.go = 1'b0;
    chk("a_busy_launch", int'(bus_a.busy), 1);
    goto(t0 + 2);
    chk("a_active_run0", int'(bus_a.stage_active), 1);
    goto(t0 + 257);
    chk("a_active_run_end", int'(bus_a.stage_active), 1);
    goto(t0 + 258);
    chk("a_active_drain", int'(bus_a.stage_active), 0);
    chk("a_busy_drain", int'(bus_a.busy), 1);
    goto(t0 + 2872);
    chk("a_busy_at_done", int'(bus_a.busy), 1);
    goto(t0 + 2873);
    chk("a_busy_after", int'(bus_a.busy), 0);
    chk("a_idx_after", int'(bus_a.stage_idx), 0);

    // Abort in stage 1 RUN, then restart
    t0 = 3410;
    goto(t0);
    bus_a.go = 1'b1;
    push_xform(1'b0, t0, 11, PER_A, 2, 1'b0);
    goto(t0 + 1);
    bus_a.go = 1'b0;
    goto(t0 + 300);
    chk("ab_idx_before", int'(bus_a.stage_idx), 1);
    bus_a.abort = 1'b1;
    goto(t0 + 301);
    bus_a.abort = 1'b0;
    chk("ab_busy", int'(bus_a.busy), 0);
    chk("ab_idx", int'(bus_a.stage_idx), 0);
    chk("ab_active", int'(bus_a.stage_active), 0);
    goto(t0 + 310);
    bus_a.go = 1'b1;
    push_xform(1'b0, t0 + 310, 11, PER_A, 11, 1'b1);
    goto(t0 + 311);
    bus_a.go = 1'b0;
    goto(t0 + 310 + 2875);

    // go held high: back-to-back transforms with one IDLE cycle between
    t0 = 6600;
    goto(t0);
    bus_a.go = 1'b1;
    push_xform(1'b0, t0, 11, PER_A, 11, 1'b1);
    push_xform(1'b0, t0 + 2873, 11, PER_A, 11, 1'b1);
    goto(t0 + 2873);
    chk("held_idle_busy", int'(bus_a.busy), 0);
    chk("held_idle_start", int'(bus_a.cnt_start), 0);
    goto(t0 + 2874);
    chk("held_relaunch_busy", int'(bus_a.busy), 1);
    goto(t0 + 2878);
    bus_a.go = 1'b0;
    goto(t0 + 2873 + 2875);

    // rst in the DRAIN of stage 5
    t0 = 12400;
    goto(t0);
    bus_a.go = 1'b1;
    push_xform(1'b0, t0, 11, PER_A, 6, 1'b0);
    goto(t0 + 1);
    bus_a.go = 1'b0;
    goto(t0 + 1564);
    chk("drain5_idx", int'(bus_a.stage_idx), 5);
    chk("drain5_active", int'(bus_a.stage_active), 0);
    chk("drain5_busy", int'(bus_a.busy), 1);
    rst = 1'b1;
    goto(t0 + 1565);
    rst = 1'b0;
    chk("mid_rst_busy", int'(bus_a.busy), 0);
    chk("mid_rst_idx", int'(bus_a.stage_idx), 0);
    chk("mid_rst_start", int'(bus_a.cnt_start), 0);
    chk("mid_rst_active", int'(bus_a.stage_active), 0);
    chk("mid_rst_done", int'(bus_a.done), 0);
    goto(t0 + 1580);

    // go and abort together in IDLE: stay idle
    t0 = 14000;
    goto(t0);
    bus_a.go = 1'b1;
    bus_a.abort = 1'b1;
    goto(t0 + 1);
    bus_a.go = 1'b0;
    bus_a.abort = 1'b0;
    chk("go_abort_busy", int'(bus_a.busy), 0);
    chk("go_abort_start", int'(bus_a.cnt_start), 0);
    goto(t0 + 5);
    chk("go_abort_busy_late", int'(bus_a.busy), 0);

`ifdef NTT_SEQ_WATCHDOG_EN
    // Stuck count: trips on the 264th RUN cycle, err sticky until rst
    t0 = 14100;
    goto(t0);
    bus_a.go = 1'b1;
    push_xform(1'b0, t0, 11, PER_A, 1, 1'b0);
    goto(t0 + 1);
    bus_a.go = 1'b0;
    stuck = 1'b1;
    goto(t0 + 265);
    chk("wd_err_before", int'(bus_a.err), 0);
    chk("wd_active_before", int'(bus_a.stage_active), 1);
    goto(t0 + 266);
    chk("wd_err", int'(bus_a.err), 1);
    chk("wd_busy", int'(bus_a.busy), 0);
    chk("wd_idx", int'(bus_a.stage_idx), 0);
    goto(t0 + 280);
    chk("wd_err_sticky", int'(bus_a.err), 1);
    rst = 1'b1;
    goto(t0 + 281);
    rst = 1'b0;
    stuck = 1'b0;
    chk("wd_err_cleared", int'(bus_a.err), 0);
    goto(t0 + 285);
`endif

    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
